// File: rtl/bit_source.sv
// Stimulus source for sequence_detector: debounced manual single-bit entry,
// or timed serial replay of a loaded pattern, each bit marked by a one-cycle ena_out strobe.
module bit_source #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned PAT_WIDTH       = 24,
   parameter int unsigned STEP_DIV        = 10,
   parameter int unsigned IDX_W           = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sw_bit,
   input  logic                 btn_step,
   input  logic                 mode,
   input  logic                 pat_load,
   input  logic [PAT_WIDTH-1:0] pat_data,
   output logic                 sig_out,
   output logic                 ena_out,
   output logic                 busy,
   output logic [IDX_W-1:0]     bit_index
);

   localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   logic sw_meta, sw_sync;
   logic btn_meta, btn_sync;
   logic mode_meta, mode_sync;
   logic mode_q;
   logic mode_chg;

   logic [DB_W-1:0] db_cnt;
   logic            btn_db;
   logic            btn_db_q;
   logic            press;

   logic [PAT_WIDTH-1:0] pat_q;

   state_t           state_q, state_n;
   logic [DIV_W-1:0] div_q, div_n;
   logic [IDX_W-1:0] idx_n;
   logic             ena_n;
   logic             sig_n;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_meta   <= 1'b0;
         sw_sync   <= 1'b0;
         btn_meta  <= 1'b0;
         btn_sync  <= 1'b0;
         mode_meta <= 1'b0;
         mode_sync <= 1'b0;
         mode_q    <= 1'b0;
      end else begin
         sw_meta   <= sw_bit;
         sw_sync   <= sw_meta;
         btn_meta  <= btn_step;
         btn_sync  <= btn_meta;
         mode_meta <= mode;
         mode_sync <= mode_meta;
         mode_q    <= mode_sync;
      end
   end

   assign mode_chg = mode_sync ^ mode_q;

   // btn_db follows btn_sync only after DEBOUNCE_CYCLES consecutive disagreeing cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_cnt   <= '0;
         btn_db   <= 1'b0;
         btn_db_q <= 1'b0;
      end else begin
         btn_db_q <= btn_db;
         if (btn_sync != btn_db) begin
            if (db_cnt == DB_LAST) begin
               btn_db <= btn_sync;
               db_cnt <= '0;
            end else begin
               db_cnt <= db_cnt + DB_W'(1);
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   assign press = btn_db & ~btn_db_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_q <= '0;
      end else if (pat_load) begin
         pat_q <= pat_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         div_q     <= '0;
         bit_index <= '0;
         ena_out   <= 1'b0;
         sig_out   <= 1'b0;
      end else begin
         state_q   <= state_n;
         div_q     <= div_n;
         bit_index <= idx_n;
         ena_out   <= ena_n;
         sig_out   <= sig_n;
      end
   end

   // Priority: mode change, then manual handling, then load abort, then replay FSM
   always_comb begin
      state_n = state_q;
      div_n   = div_q;
      idx_n   = bit_index;
      ena_n   = 1'b0;
      sig_n   = sig_out;
      if (mode_chg) begin
         state_n = IDLE;
         div_n   = '0;
         idx_n   = '0;
      end else if (!mode_sync) begin
         state_n = IDLE;
         if (press) begin
            ena_n = 1'b1;
            sig_n = sw_sync;
         end
      end else if (pat_load) begin
         state_n = IDLE;
         div_n   = '0;
         idx_n   = '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (press) begin
                  state_n = RUN;
                  div_n   = '0;
                  idx_n   = '0;
               end
            end
            RUN: begin
               if (div_q == DIV_LAST) begin
                  div_n = '0;
                  ena_n = 1'b1;
                  sig_n = pat_q[bit_index];
                  idx_n = bit_index + IDX_W'(1);
                  if (bit_index == IDX_LAST) begin
                     state_n = DONE;
                  end
               end else begin
                  div_n = div_q + DIV_W'(1);
               end
            end
            default: begin
               state_n = IDLE;
               div_n   = '0;
               idx_n   = '0;
            end
         endcase
      end
   end

   assign busy = (state_q == RUN);

endmodule

// File: tb/tb_bit_source.sv
// Randomized and directed bench for bit_source against a cycle-level behavioural model.
module tb_bit_source;

   localparam int PW   = 24;
   localparam int STEP = 10;
   localparam int DEB  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          sw_bit = 1'b0;
   logic          btn_step = 1'b0;
   logic          mode = 1'b0;
   logic          pat_load = 1'b0;
   logic [PW-1:0] pat_data = '0;
   logic          sig_out, ena_out, busy;
   logic [4:0]    bit_index;

   bit_source #(
      .DEBOUNCE_CYCLES(DEB),
      .PAT_WIDTH(PW),
      .STEP_DIV(STEP),
      .IDX_W(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .sw_bit(sw_bit),
      .btn_step(btn_step),
      .mode(mode),
      .pat_load(pat_load),
      .pat_data(pat_data),
      .sig_out(sig_out),
      .ena_out(ena_out),
      .busy(busy),
      .bit_index(bit_index)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int tcyc = 0;
   int pulses = 0;
   int last_ena = 0;
   bit prev_ena = 1'b0;
   bit cap[$];
   int ecyc[$];

   always @(posedge clk) tcyc <= tcyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, tcyc);
      end
   endtask

   // Behavioural model: synchronizer delay lines, disagreement run length,
   // and replay timing derived arithmetically from the cycle RUN was entered.
   bit m_sw1, m_sw2, m_bt1, m_bt2, m_md1, m_md2, m_modeq;
   bit m_db, m_dbq, m_running, m_ena, m_sig;
   int m_run_len, m_run_start, m_idx, mcyc;
   logic [PW-1:0] m_pat;

   task automatic model_reset();
      {m_sw1, m_sw2, m_bt1, m_bt2, m_md1, m_md2, m_modeq} = '0;
      {m_db, m_dbq, m_running, m_ena, m_sig} = '0;
      m_run_len = 0;
      m_run_start = 0;
      m_idx = 0;
      m_pat = '0;
   endtask

   task automatic model_step();
      bit press, chg;
      int n, k;
      mcyc  = mcyc + 1;
      press = m_db && !m_dbq;
      chg   = (m_md2 != m_modeq);
      m_ena = 1'b0;
      if (chg || (pat_load && m_md2)) begin
         m_running = 1'b0;
         m_idx = 0;
      end else if (!m_md2) begin
         m_running = 1'b0;
         if (press) begin
            m_ena = 1'b1;
            m_sig = m_sw2;
         end
      end else if (m_running) begin
         n = mcyc - m_run_start;
         if (n % STEP == 0) begin
            k = n / STEP;
            m_sig = m_pat[k-1];
            m_ena = 1'b1;
            m_idx = k;
            if (k == PW) m_running = 1'b0;
         end
      end else if (press) begin
         m_running = 1'b1;
         m_run_start = mcyc;
         m_idx = 0;
      end
      if (pat_load) m_pat = pat_data;
      m_dbq = m_db;
      if (m_bt2 != m_db) begin
         m_run_len = m_run_len + 1;
         if (m_run_len == DEB) begin
            m_db = m_bt2;
            m_run_len = 0;
         end
      end else begin
         m_run_len = 0;
      end
      m_modeq = m_md2;
      m_md2 = m_md1; m_md1 = mode;
      m_sw2 = m_sw1; m_sw1 = sw_bit;
      m_bt2 = m_bt1; m_bt1 = btn_step;
   endtask

   initial mcyc = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) model_reset();
      else model_step();
   end

   task automatic check_cycle();
      chk("ena_out", int'(ena_out), int'(m_ena));
      chk("sig_out", int'(sig_out), int'(m_sig));
      chk("busy", int'(busy), int'(m_running));
      chk("bit_index", int'(bit_index), m_idx);
      if (ena_out) begin
         checks = checks + 1;
         if (prev_ena) begin
            errors = errors + 1;
            $display("FAIL ena_back_to_back: got 1 expected 0 (cycle %0d)", tcyc);
         end
         cap.push_back(sig_out);
         ecyc.push_back(tcyc);
         pulses = pulses + 1;
         last_ena = tcyc;
      end
      prev_ena = ena_out;
   endtask

   always @(negedge clk) begin
      if (rst) check_cycle();
      else prev_ena = 1'b0;
   end

   task automatic press_btn(input int hold);
      btn_step = 1'b1;
      repeat (hold) @(negedge clk);
      btn_step = 1'b0;
      repeat (hold) @(negedge clk);
   endtask

   task automatic wait_cap(input int n, input int bound, input string name);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         #1;
         if (cap.size() >= n) break;
      end
      chk({name, "_timeout"}, int'(cap.size() >= n), 1);
   endtask

   task automatic check_replay(input string name, input logic [PW-1:0] pv);
      bit first8 [8] = '{0, 0, 0, 1, 0, 0, 1, 1};
      chk({name, "_count"}, cap.size(), PW);
      for (int i = 0; i < 8; i++)
         chk({name, "_lit"}, (cap.size() > i) ? int'(cap[i]) : -1, int'(first8[i]));
      for (int i = 0; i < PW; i++)
         chk({name, "_bit"}, (cap.size() > i) ? int'(cap[i]) : -1, int'(pv[i]));
      for (int i = 0; i + 1 < ecyc.size(); i++)
         chk({name, "_spacing"}, ecyc[i+1] - ecyc[i], STEP);
      chk({name, "_idx"}, int'(bit_index), PW);
      chk({name, "_busy"}, int'(busy), 0);
      chk({name, "_model_idx"}, m_idx, PW);
   endtask

   initial begin
      logic [PW-1:0] pat_v;
      int base, t0;
      pat_v = 24'b110010101110100011001000;

      repeat (3) @(negedge clk);
      #1;
      chk("reset_sig", int'(sig_out), 0);
      chk("reset_ena", int'(ena_out), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_idx", int'(bit_index), 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      // Bounce rejection
      sw_bit = 1'b1;
      base = pulses;
      for (int i = 0; i < 10; i++) begin
         btn_step = ~btn_step;
         repeat (3) @(negedge clk);
      end
      btn_step = 1'b1;
      t0 = tcyc;
      repeat (40) @(negedge clk);
      btn_step = 1'b0;
      repeat (30) @(negedge clk);
      #1;
      chk("bounce_pulses", pulses - base, 1);
      chk("bounce_latency", last_ena - t0, 2 + DEB + 1);

      // Manual entry
      cap.delete();
      sw_bit = 1'b1;
      press_btn(25);
      sw_bit = 1'b0;
      press_btn(25);
      #1;
      chk("manual_count", cap.size(), 2);
      chk("manual_first", (cap.size() > 0) ? int'(cap[0]) : -1, 1);
      chk("manual_second", (cap.size() > 1) ? int'(cap[1]) : -1, 0);
      chk("manual_idx", int'(bit_index), 0);
      chk("manual_busy", int'(busy), 0);

      // Auto replay
      mode = 1'b1;
      repeat (5) @(negedge clk);
      pat_data = pat_v;
      pat_load = 1'b1;
      @(negedge clk);
      pat_load = 1'b0;
      repeat (3) @(negedge clk);
      cap.delete();
      ecyc.delete();
      press_btn(25);
      wait_cap(PW, 400, "auto");
      repeat (15) @(negedge clk);
      #1;
      check_replay("auto", pat_v);

      // Restart from DONE
      cap.delete();
      ecyc.delete();
      press_btn(25);
      wait_cap(PW, 400, "restart");
      repeat (15) @(negedge clk);
      #1;
      check_replay("restart", pat_v);

      // Abort with pat_load landing on the divider's terminal count
      cap.delete();
      press_btn(25);
      wait_cap(5, 300, "abort_wait");
      repeat (9) @(negedge clk);
      pat_load = 1'b1;
      @(negedge clk);
      #1;
      pat_load = 1'b0;
      chk("abort_no_strobe", int'(ena_out), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_idx", int'(bit_index), 0);
      repeat (30) @(negedge clk);
      #1;
      chk("abort_silent", cap.size(), 5);

      // Asynchronous reset mid-replay
      press_btn(25);
      wait_cap(7, 300, "rst_wait");
      @(posedge clk);
      #1 rst = 1'b0;
      #2;
      chk("arst_sig", int'(sig_out), 0);
      chk("arst_ena", int'(ena_out), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_idx", int'(bit_index), 0);
      #1 rst = 1'b1;
      base = pulses;
      repeat (40) @(negedge clk);
      #1;
      chk("arst_no_strobe", pulses - base, 0);
      cap.delete();
      press_btn(25);
      wait_cap(1, 300, "arst_restart");
      chk("arst_pattern_cleared", (cap.size() > 0) ? int'(cap[0]) : -1, 0);

      // Randomized mix of presses, mode flips, loads and switch changes
      for (int a = 0; a < 150; a++) begin
         case ($urandom_range(0, 5))
            0, 1: begin
               for (int b = 0; b < int'($urandom_range(0, 6)); b++) begin
                  btn_step = ~btn_step;
                  repeat ($urandom_range(1, 4)) @(negedge clk);
               end
               btn_step = 1'b1;
               repeat ($urandom_range(20, 40)) @(negedge clk);
               btn_step = 1'b0;
               repeat ($urandom_range(20, 40)) @(negedge clk);
            end
            2: begin
               mode = ~mode;
               repeat ($urandom_range(1, 30)) @(negedge clk);
            end
            3: begin
               pat_data = 24'($urandom);
               pat_load = 1'b1;
               @(negedge clk);
               pat_load = 1'b0;
            end
            4: begin
               sw_bit = 1'($urandom);
               repeat ($urandom_range(1, 10)) @(negedge clk);
            end
            default: repeat ($urandom_range(50, 300)) @(negedge clk);
         endcase
      end
      repeat (300) @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
